// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem reads,
// buffers one instruction under stall, squashes stale reads after redirects and stops on HALT.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SQUASH,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic        r_pend_valid;
    logic [15:0] r_pend_instr;
    logic [15:0] r_pend_pc;

    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus2;

    logic        w_req;
    logic        w_halted;
    logic        w_ack;
    logic        w_accept;
    logic        w_is_halt;
    logic        w_hold;

    // An ack only counts while a request is being presented.
    assign w_ack     = imem_ack & w_req;
    assign w_accept  = w_ack & (r_state == S_FETCH) & ~redirect;
    assign w_is_halt = (imem_rdata[15:12] == HALT_OPCODE);
    assign w_hold    = stall & r_if_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = (w_req && !imem_ack) ? S_SQUASH : S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_FETCH;
                S_FETCH:  if (w_ack && w_is_halt) w_state_nxt = S_HALT;
                S_SQUASH: if (w_ack) w_state_nxt = S_FETCH;
                S_HALT:   w_state_nxt = S_HALT;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_req    = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            S_FETCH, S_SQUASH: w_req = ~r_pend_valid;
            S_HALT:            w_halted = 1'b1;
            default:           w_req = 1'b0;
        endcase
    end

    // A squashed or same-cycle-redirect ack never advances the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_accept) begin
            r_pc <= r_pc + 16'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
        end else if (redirect) begin
            r_pend_valid <= 1'b0;
        end else if (w_hold) begin
            if (w_accept) r_pend_valid <= 1'b1;
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    // NOTE: buffer payload carries no reset; it is only ever read behind r_pend_valid.
    always_ff @(posedge clk) begin
        if (w_hold && w_accept) begin
            r_pend_instr <= imem_rdata;
            r_pend_pc    <= r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid    <= 1'b0;
            r_if_instr    <= 16'h0000;
            r_if_pc       <= 16'h0000;
            r_if_pc_plus2 <= 16'h0000;
        end else if (redirect) begin
            r_if_valid <= 1'b0;
        end else if (!w_hold) begin
            if (r_pend_valid) begin
                r_if_valid    <= 1'b1;
                r_if_instr    <= r_pend_instr;
                r_if_pc       <= r_pend_pc;
                r_if_pc_plus2 <= r_pend_pc + 16'd2;
            end else if (w_accept) begin
                r_if_valid    <= 1'b1;
                r_if_instr    <= imem_rdata;
                r_if_pc       <= r_pc;
                r_if_pc_plus2 <= r_pc + 16'd2;
            end else begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign halted      = w_halted;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus2 = r_if_pc_plus2;

endmodule
